// File: rtl/mac_rx_frame_arbiter.sv
// Two-port RX frame arbiter: merges two MAC RX FIFO pipes into one tagged stream,
// holding the grant for whole frames and truncating frames longer than MAX_WORDS.
module mac_rx_frame_arbiter #(
  parameter int unsigned NIC_WIDTH = 10,
  parameter int unsigned MAX_WORDS = 1518
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NIC_WIDTH-1:0] in0_data,
  input  logic                 in0_ack,
  output logic                 in0_req,
  input  logic [NIC_WIDTH-1:0] in1_data,
  input  logic                 in1_ack,
  output logic                 in1_req,
  output logic [NIC_WIDTH:0]   out_data,
  output logic                 out_ack,
  input  logic                 out_req,
  output logic [15:0]          frame_len,
  output logic                 frame_port,
  output logic                 frame_done,
  output logic                 err_oversize
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] WC_LAST = CNT_W'(MAX_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

  state_t             state;
  logic               g;
  logic               ls;
  logic [CNT_W-1:0]   wc;
  logic [CNT_W-1:0]   bc;

  logic [NIC_WIDTH-1:0] sel_data;
  logic                 sel_ack;
  logic                 sel_req;
  logic                 xfer;
  logic                 word_last;
  logic                 word_keep;
  logic                 trunc;
  logic [SUM_W-1:0]     bc_sum;
  logic [CNT_W-1:0]     bc_sat;

  assign sel_data  = g ? in1_data : in0_data;
  assign sel_ack   = g ? in1_ack  : in0_ack;
  assign word_last = sel_data[NIC_WIDTH-1];
  assign word_keep = sel_data[0];

  // Pop request towards the granted FIFO only; reset gates it immediately.
  always_comb begin
    sel_req = 1'b0;
    case (state)
      BUSY:    sel_req = out_req;
      DROP:    sel_req = 1'b1;
      default: sel_req = 1'b0;
    endcase
    if (reset) sel_req = 1'b0;
  end

  assign in0_req = sel_req & ~g;
  assign in1_req = sel_req & g;
  assign out_ack = (state == BUSY) & sel_ack & ~reset;
  assign xfer    = sel_req & sel_ack;

  // The word that hits the size limit without its own tlast is closed off here.
  assign trunc    = (state == BUSY) & ~word_last & (wc == WC_LAST);
  assign out_data = {g, word_last | trunc, sel_data[NIC_WIDTH-2:0]};

  assign bc_sum = {1'b0, bc} + SUM_W'(word_keep);
  assign bc_sat = bc_sum[CNT_W] ? CNT_MAX : bc_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      g            <= 1'b0;
      ls           <= 1'b1;
      wc           <= '0;
      bc           <= '0;
      frame_len    <= '0;
      frame_port   <= 1'b0;
      frame_done   <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      frame_done   <= 1'b0;
      err_oversize <= 1'b0;
      case (state)
        IDLE: begin
          wc <= '0;
          bc <= '0;
          if (in0_ack && in1_ack) begin
            g     <= ~ls;
            state <= BUSY;
          end else if (in0_ack) begin
            g     <= 1'b0;
            state <= BUSY;
          end else if (in1_ack) begin
            g     <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (xfer) begin
            wc <= (wc == CNT_MAX) ? wc : wc + CNT_W'(1);
            bc <= bc_sat;
            if (word_last) begin
              state      <= IDLE;
              ls         <= g;
              frame_done <= 1'b1;
              frame_len  <= bc_sat;
              frame_port <= g;
            end else if (trunc) begin
              state        <= DROP;
              err_oversize <= 1'b1;
              frame_done   <= 1'b1;
              frame_len    <= bc_sat;
              frame_port   <= g;
            end
          end
        end
        DROP: begin
          // Discard the tail of an oversize frame up to its real tlast.
          if (xfer && word_last) begin
            state <= IDLE;
            ls    <= g;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_rx_frame_arbiter.sv
// Scoreboard bench for mac_rx_frame_arbiter: FIFO models feed both ports, a frame-level
// model predicts output words and completion reports, a negedge monitor compares.
module tb_mac_rx_frame_arbiter;

  localparam int unsigned NW = 10;
  localparam int unsigned MW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NW-1:0] in0_data = '0;
  logic          in0_ack = 1'b0;
  logic          in0_req;
  logic [NW-1:0] in1_data = '0;
  logic          in1_ack = 1'b0;
  logic          in1_req;
  logic [NW:0]   out_data;
  logic          out_ack;
  logic          out_req = 1'b0;
  logic [15:0]   frame_len;
  logic          frame_port;
  logic          frame_done;
  logic          err_oversize;

  mac_rx_frame_arbiter #(.NIC_WIDTH(NW), .MAX_WORDS(MW)) dut (
    .clk(clk), .reset(reset),
    .in0_data(in0_data), .in0_ack(in0_ack), .in0_req(in0_req),
    .in1_data(in1_data), .in1_ack(in1_ack), .in1_req(in1_req),
    .out_data(out_data), .out_ack(out_ack), .out_req(out_req),
    .frame_len(frame_len), .frame_port(frame_port),
    .frame_done(frame_done), .err_oversize(err_oversize)
  );

  always #5 clk = ~clk;

  // Source FIFO contents, expected output words and {err, len} per frame, per port.
  logic [NW-1:0] src0[$], src1[$];
  logic [NW:0]   exp0[$], exp1[$];
  logic [16:0]   meta0[$], meta1[$];
  logic          start_log[$];

  int n_chk = 0, n_fail = 0;
  int pops0 = 0, pops1 = 0, dones = 0, errs = 0;
  bit stall_en = 1'b0;
  int req_mode = 0;
  bit mirror_chk = 1'b0;

  bit          in_frame = 1'b0, cur_port = 1'b0, act_port = 1'b0;
  bit          exp_done = 1'b0, exp_err = 1'b0, exp_port = 1'b0;
  logic [15:0] exp_len = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Frame model: words beyond MW are dropped, word MW gets tlast, length sums tkeep passed.
  task automatic add_frame(input bit p, input int n, input bit rnd_keep, input bit last_keep);
    logic [NW-1:0] w;
    logic [NW:0]   ow;
    logic [15:0]   len;
    bit            keep;
    len = '0;
    for (int i = 0; i < n; i++) begin
      keep = rnd_keep ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!rnd_keep && i == n - 1) keep = last_keep;
      w = {(i == n - 1), 8'($urandom), keep};
      if (p) src1.push_back(w); else src0.push_back(w);
      if (i < int'(MW)) begin
        ow = {p, w};
        if (i == int'(MW) - 1) ow[NW-1] = 1'b1;
        if (p) exp1.push_back(ow); else exp0.push_back(ow);
        len = len + 16'(keep);
      end
    end
    if (p) meta1.push_back({(n > int'(MW)), len}); else meta0.push_back({(n > int'(MW)), len});
  endtask

  task automatic drive();
    in0_ack  = (src0.size() != 0) && (!stall_en || $urandom_range(0, 3) != 0);
    in0_data = (src0.size() != 0) ? src0[0] : '0;
    in1_ack  = (src1.size() != 0) && (!stall_en || $urandom_range(0, 3) != 0);
    in1_data = (src1.size() != 0) ? src1[0] : '0;
    case (req_mode)
      0:       out_req = 1'b1;
      1:       out_req = ~out_req;
      default: out_req = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      drive();
    end
  end

  task automatic mon_step();
    logic [NW:0] w, ew;
    logic [16:0] m;
    bit          p;
    if (reset) begin
      check("rst_out_ack", out_ack, 0);
      check("rst_in0_req", in0_req, 0);
      check("rst_in1_req", in1_req, 0);
      check("rst_frame_done", frame_done, exp_done);
      in_frame = 1'b0;
      exp_done = 1'b0;
      return;
    end
    if (frame_done) dones++;
    if (err_oversize) errs++;
    if (frame_done || err_oversize || exp_done) begin
      check("frame_done", frame_done, exp_done);
      check("err_oversize", err_oversize, exp_done & exp_err);
      if (exp_done) begin
        check("frame_len", frame_len, exp_len);
        check("frame_port", frame_port, exp_port);
      end
    end
    exp_done = 1'b0;
    check("dual_pop", in0_req & in1_req, 0);
    if (mirror_chk && in_frame) check("in1_req_mirror", in1_req, out_req);
    if (out_ack && out_req) begin
      w = out_data;
      p = w[NW];
      if (!in_frame) begin
        in_frame = 1'b1;
        cur_port = p;
        act_port = p;
        start_log.push_back(p);
      end else begin
        check("no_interleave", p, cur_port);
      end
      ew = '0;
      if (p && exp1.size() != 0) ew = exp1.pop_front();
      else if (!p && exp0.size() != 0) ew = exp0.pop_front();
      check("out_word", w, ew);
      if (w[NW-1]) begin
        in_frame = 1'b0;
        m = '0;
        if (p && meta1.size() != 0) m = meta1.pop_front();
        else if (!p && meta0.size() != 0) m = meta0.pop_front();
        exp_done = 1'b1;
        exp_err  = m[16];
        exp_len  = m[15:0];
        exp_port = p;
      end
    end
    if (in0_req && in0_ack) begin
      check("pop_port0_granted", act_port, 0);
      if (src0.size() != 0) void'(src0.pop_front());
      pops0++;
    end
    if (in1_req && in1_ack) begin
      check("pop_port1_granted", act_port, 1);
      if (src1.size() != 0) void'(src1.pop_front());
      pops1++;
    end
  endtask

  always @(negedge clk) mon_step();

  task automatic wait_drain(input int budget);
    bit drained;
    drained = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (src0.size() == 0 && src1.size() == 0 && exp0.size() == 0 &&
          exp1.size() == 0 && !in_frame) begin
        drained = 1'b1;
        break;
      end
    end
    check("drain_timeout", drained, 1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    src0.delete(); src1.delete(); exp0.delete(); exp1.delete();
    meta0.delete(); meta1.delete();
    repeat (2) @(negedge clk);
    #1;
    check("rst_frame_len", frame_len, 0);
    check("rst_frame_port", frame_port, 0);
    check("rst_done_reg", frame_done, 0);
    check("rst_err_reg", err_oversize, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int b0, b1, bd, be;
    bit got;
    bit exp_order[4];
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};

    do_reset();

    // Single 4-word frame on port 0.
    b0 = pops0; bd = dones;
    add_frame(1'b0, 4, 1'b0, 1'b1);
    wait_drain(200);
    check("p0_4w_pops", pops0 - b0, 4);
    check("p0_4w_dones", dones - bd, 1);

    // Both ports pending from reset: round-robin starting with port 0.
    do_reset();
    start_log.delete();
    add_frame(1'b0, 2, 1'b0, 1'b1);
    add_frame(1'b1, 2, 1'b0, 1'b1);
    add_frame(1'b0, 2, 1'b0, 1'b1);
    add_frame(1'b1, 2, 1'b0, 1'b1);
    wait_drain(300);
    check("rr_frames", start_log.size(), 4);
    for (int i = 0; i < 4 && i < start_log.size(); i++)
      check($sformatf("rr_order_%0d", i), start_log[i], exp_order[i]);

    // Throttled downstream on a port-1 frame.
    req_mode = 1; mirror_chk = 1'b1;
    b1 = pops1;
    add_frame(1'b1, 6, 1'b0, 1'b1);
    wait_drain(300);
    check("p1_toggle_pops", pops1 - b1, 6);
    req_mode = 0; mirror_chk = 1'b0;

    // Oversize frame: 12 words with MAX_WORDS = 8.
    b0 = pops0; bd = dones; be = errs;
    add_frame(1'b0, 12, 1'b0, 1'b1);
    wait_drain(300);
    check("oversize_pops", pops0 - b0, 12);
    check("oversize_dones", dones - bd, 1);
    check("oversize_errs", errs - be, 1);

    // Exactly MAX_WORDS words ends normally; last tkeep=0 shortens the length.
    be = errs;
    add_frame(1'b1, 8, 1'b0, 1'b1);
    add_frame(1'b0, 5, 1'b0, 1'b0);
    wait_drain(300);
    check("exact_max_no_err", errs - be, 0);

    // Reset two words into a five-word frame.
    b0 = pops0; bd = dones;
    add_frame(1'b0, 5, 1'b0, 1'b1);
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (pops0 >= b0 + 2) begin
        got = 1'b1;
        break;
      end
    end
    check("mid_reset_reach", got, 1);
    do_reset();
    check("mid_reset_pops", pops0 - b0, 2);
    check("mid_reset_no_done", dones - bd, 0);
    start_log.delete();
    add_frame(1'b0, 3, 1'b0, 1'b1);
    wait_drain(200);
    check("post_reset_frames", start_log.size(), 1);
    if (start_log.size() != 0) check("post_reset_port", start_log[0], 0);
    check("post_reset_done", dones - bd, 1);

    // Randomised traffic with input stalls and downstream backpressure.
    stall_en = 1'b1;
    req_mode = 2;
    for (int r = 0; r < 4; r++) begin
      for (int f = 0; f < 10; f++)
        add_frame(1'($urandom_range(0, 1)), $urandom_range(1, 11), 1'b1, 1'b1);
      wait_drain(4000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_rx_frame_arbiter.md
MAC_RX_FRAME_ARBITER -- requirements
Module: mac_rx_frame_arbiter

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
  NIC_WIDTH, 10, pipe word width; word layout {tlast[NIC_WIDTH-1], tdata[NIC_WIDTH-2:1], tkeep[0]}
  MAX_WORDS, 1518, maximum words per frame before truncation
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  input  1  clock
  reset  input  1  reset, synchronous, active-high
  in0_data  input  NIC_WIDTH  RX FIFO 0 pipe word
  in0_ack  input  1  RX FIFO 0 non-empty (word valid)
  in0_req  output  1  pop request to RX FIFO 0
  in1_data  input  NIC_WIDTH  RX FIFO 1 pipe word
  in1_ack  input  1  RX FIFO 1 non-empty
  in1_req  output  1  pop request to RX FIFO 1
  out_data  output  NIC_WIDTH+1  {port_id, word}; port_id is MSB
  out_ack  output  1  out_data valid
  out_req  input  1  downstream pop request
  frame_len  output  16  byte count of last completed frame
  frame_port  output  1  source port of last completed frame
  frame_done  output  1  one-cycle pulse: frame_len/frame_port updated
  err_oversize  output  1  one-cycle pulse: frame truncated at MAX_WORDS

Function
REQ-003 Transfer on an input SHALL occur in a cycle where inX_req=1 and inX_ack=1; on output where out_ack=1 and out_req=1.
REQ-004 States SHALL be IDLE, BUSY, DROP; grant register g (1 bit), last-served register ls (1 bit), word counter wc (16 bit), byte counter bc (16 bit).
REQ-005 IDLE: in0_req=in1_req=out_ack=0; if exactly one inX_ack=1, g<=X, goto BUSY; if both, g<=~ls (round-robin), goto BUSY; else stay; wc<=0, bc<=0.
REQ-006 BUSY: out_ack=in{g}_ack, in{g}_req=out_req, other in_req=0, out_data={g, in{g}_data} combinationally (zero-cycle latency); non-granted port never popped.
REQ-007 BUSY transfer: wc<=wc+1, bc<=bc+tkeep.
REQ-008 BUSY transfer with tlast=1: goto IDLE, ls<=g, next cycle frame_done=1, frame_len=bc+tkeep of final word, frame_port=g.
REQ-009 BUSY transfer with tlast=0 and wc==MAX_WORDS-1: out_data tlast bit SHALL be forced to 1 in that cycle, err_oversize pulses next cycle, frame_done pulses next cycle with frame_len=bytes passed, goto DROP.
REQ-010 DROP: out_ack=0, in{g}_req=1, discard words; on transfer with tlast=1 goto IDLE, ls<=g; no frame_done for dropped words.
REQ-011 Frame length counting SHALL saturate at 16'hFFFF; wc SHALL never wrap before MAX_WORDS.
REQ-012 Grant SHALL be held for whole frame regardless of other port's ack; re-arbitration only in IDLE (one idle cycle minimum between frames).
REQ-013 If in{g}_ack drops mid-frame in BUSY, out_ack SHALL follow (0) and state SHALL hold; no timeout.
REQ-014 Word with tlast=1 arriving on the truncation cycle SHALL be treated per REQ-008 (normal end, no error).

Reset
REQ-015 reset=1 at any clock edge SHALL force state IDLE, g=0, ls=1 (port 0 wins first tie), wc=0, bc=0, frame_len=0, frame_port=0, frame_done=0, err_oversize=0; in0_req=in1_req=out_ack=0 while reset=1 (combinational gating).
REQ-016 Reset mid-frame SHALL abandon the frame without frame_done; partially popped FIFO words are not replayed.

Verification
REQ-017 Port 0 only, 4-word frame, tkeep all 1, out_req=1 -> 4 output words with MSB=0, last with tlast=1; frame_done next cycle, frame_len=4, frame_port=0.
REQ-018 Both acks high from reset, 2-word frames each -> port 0 frame first, then port 1, then port 0; no interleaving of words within a frame.
REQ-019 out_req toggled 1/0 during 6-word port-1 frame -> in1_req mirrors out_req, exactly 6 pops, frame_len=6.
REQ-020 MAX_WORDS=8, 12-word frame on port 0 -> 8 words out, 8th has tlast forced 1, err_oversize and frame_done (len 8) pulse once, remaining 4 words popped with out_ack=0, then IDLE.
REQ-021 Frame with last word tkeep=0 (5 words) -> frame_len=4.
REQ-022 reset asserted after 2 of 5 words -> outputs zero next cycle, no frame_done; after release, new frame on port 0 arbitrated normally.
